// File: rtl/loader_defs_pkg.sv
// -----------------------------------------------------------------------------
// loader_defs
// Shared definitions for the UART ROM loader: FSM state encodings for the
// session controller and the UART receiver, the UART data-bit count and the
// width of the length field at the head of a program image.
// No ports (package).
// -----------------------------------------------------------------------------
package loader_defs;

  localparam int UART_BITS = 8;   // data bits per UART character (8N1)
  localparam int LEN_W     = 16;  // word-count field width and word index width

  // Session controller states. ST_CSUM is only reachable when the design is
  // built with ROM_LOADER_CSUM_EN.
  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_LEN0 = 3'd1,
    ST_LEN1 = 3'd2,
    ST_DATA = 3'd3,
    ST_CSUM = 3'd4,
    ST_DONE = 3'd5,
    ST_ERR  = 3'd6
  } state_t;

  // UART receiver states.
  typedef enum logic [1:0] {
    RX_IDLE  = 2'd0,
    RX_START = 2'd1,
    RX_DATA  = 2'd2,
    RX_STOP  = 2'd3
  } rx_state_t;

endpackage

// File: rtl/uart_rx.sv
// -----------------------------------------------------------------------------
// uart_rx
// 8N1 UART receiver, LSB first. The serial input is double-flopped before use.
// A falling edge while idle starts a character; the start bit is re-checked
// half a bit period later (a high level there is treated as a glitch), then
// each data bit and the stop bit are sampled one bit period apart.
//
// Parameters:
//   DIV         bit period in clock cycles (>= 2)
// Ports:
//   clk         system clock
//   rst         synchronous active-high reset
//   rx          asynchronous serial input, idle high
//   rx_data     last received character, stable while byte_valid is high
//   byte_valid  one-cycle pulse: character received with a good stop bit
//   frame_err   one-cycle pulse: stop bit read low, character discarded
// -----------------------------------------------------------------------------
module uart_rx
  import loader_defs::*;
#(
  parameter int DIV = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx,
  output logic [7:0] rx_data,
  output logic       byte_valid,
  output logic       frame_err
);

  localparam int CNT_W = (DIV > 2) ? $clog2(DIV) : 1;

  logic             rx_meta;
  logic             rx_sync;
  logic             rx_prev;
  logic [CNT_W-1:0] cnt;
  logic [2:0]       bit_cnt;
  logic [7:0]       shreg;
  logic             tick_full;
  logic             tick_half;
  logic             fall;

  rx_state_t rx_state;
  rx_state_t rx_state_next;

  assign tick_full = (cnt == CNT_W'(DIV - 1));
  assign tick_half = (cnt == CNT_W'(DIV / 2 - 1));
  assign fall      = rx_prev & ~rx_sync;
  assign rx_data   = shreg;

  always_ff @(posedge clk) begin
    if (rst) rx_state <= RX_IDLE;
    else     rx_state <= rx_state_next;
  end

  // NOTE: every variable assigned in always_comb gets a default first, so no
  // path can leave it unassigned and infer a latch.
  always_comb begin
    rx_state_next = rx_state;
    case (rx_state)
      RX_IDLE:  if (fall) rx_state_next = RX_START;
      RX_START: if (tick_half) rx_state_next = rx_sync ? RX_IDLE : RX_DATA;
      RX_DATA:  if (tick_full && bit_cnt == 3'(UART_BITS - 1)) rx_state_next = RX_STOP;
      RX_STOP:  if (tick_full) rx_state_next = RX_IDLE;
      default:  rx_state_next = RX_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop sees
  // the pre-edge value of the others (the synchronizer chain relies on this).
  always_ff @(posedge clk) begin
    if (rst) begin
      rx_meta    <= 1'b1;
      rx_sync    <= 1'b1;
      rx_prev    <= 1'b1;
      cnt        <= '0;
      bit_cnt    <= '0;
      shreg      <= '0;
      byte_valid <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      rx_meta    <= rx;
      rx_sync    <= rx_meta;
      rx_prev    <= rx_sync;
      byte_valid <= 1'b0;
      frame_err  <= 1'b0;
      case (rx_state)
        RX_IDLE: begin
          cnt     <= '0;
          bit_cnt <= '0;
        end
        // The counter restarts at the mid-start-bit point so that every later
        // sample lands near the middle of its bit.
        RX_START: cnt <= tick_half ? '0 : cnt + CNT_W'(1);
        RX_DATA: begin
          if (tick_full) begin
            cnt     <= '0;
            shreg   <= {rx_sync, shreg[7:1]};
            bit_cnt <= bit_cnt + 3'd1;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        RX_STOP: begin
          if (tick_full) begin
            cnt        <= '0;
            byte_valid <= rx_sync;
            frame_err  <= ~rx_sync;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        default: cnt <= '0;
      endcase
    end
  end

endmodule

// File: rtl/uart_rom_loader.sv
// -----------------------------------------------------------------------------
// uart_rom_loader
// Boot-time program loader feeding the instruction ROM write port. Receives
// an image framed as LEN_LO, LEN_HI (word count N) followed by 4*N data bytes
// over UART, packs little-endian 32-bit words and writes word k to
// BASE_ADDR + 4*k with a single-cycle strobe.
//
// Build option: ROM_LOADER_CSUM_EN -- when defined, a trailing checksum byte
// (mod-256 sum of the data bytes) is expected and checked before DONE.
//
// Parameters: CLK_FREQ, BAUD (bit period = CLK_FREQ/BAUD), BASE_ADDR, MAX_WORDS
// Ports:
//   clk         system clock
//   rst         synchronous active-high reset
//   rx_i        UART serial input, asynchronous, idle high
//   load_req_i  level; high requests a load session, low aborts/acknowledges
//   wen_o       ROM write strobe, one cycle per word
//   w_addr_o    ROM byte address (held between writes)
//   w_data_o    ROM write data (held between writes)
//   busy_o      session in progress (CPU hold)
//   done_o      image loaded successfully
//   err_o       session failed
// -----------------------------------------------------------------------------
module uart_rom_loader
  import loader_defs::*;
#(
  parameter int          CLK_FREQ  = 50000000,
  parameter int          BAUD      = 115200,
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
  parameter int          MAX_WORDS = 4096
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rx_i,
  input  logic        load_req_i,
  output logic        wen_o,
  output logic [31:0] w_addr_o,
  output logic [31:0] w_data_o,
  output logic        busy_o,
  output logic        done_o,
  output logic        err_o
);

  localparam int DIV = CLK_FREQ / BAUD;

`ifdef ROM_LOADER_CSUM_EN
  localparam state_t ST_AFTER_DATA = ST_CSUM;
`else
  localparam state_t ST_AFTER_DATA = ST_DONE;
`endif

  logic [7:0]       rx_byte;
  logic             byte_valid;
  logic             frame_err;

  state_t           state;
  state_t           state_next;

  logic [7:0]       len_lo;
  logic [LEN_W-1:0] len_rx;
  logic [LEN_W-1:0] n_words;
  logic [LEN_W-1:0] word_cnt;
  logic [1:0]       byte_idx;
  logic [23:0]      word_buf;     // first three bytes of the word in progress
  logic             in_session;
  logic             abort;
  logic             last_word;
`ifdef ROM_LOADER_CSUM_EN
  logic [7:0]       csum;
`endif

  uart_rx #(
    .DIV (DIV)
  ) u_uart_rx (
    .clk        (clk),
    .rst        (rst),
    .rx         (rx_i),
    .rx_data    (rx_byte),
    .byte_valid (byte_valid),
    .frame_err  (frame_err)
  );

  assign in_session = state inside {ST_LEN0, ST_LEN1, ST_DATA, ST_CSUM};
  assign abort      = in_session & ~load_req_i;
  assign len_rx     = {rx_byte, len_lo};
  assign last_word  = (word_cnt == n_words - LEN_W'(1));

  assign busy_o = in_session;
  assign done_o = (state == ST_DONE);
  assign err_o  = (state == ST_ERR);

  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE: if (load_req_i) state_next = ST_LEN0;
      ST_LEN0: begin
        if (frame_err)       state_next = ST_ERR;
        else if (byte_valid) state_next = ST_LEN1;
      end
      ST_LEN1: begin
        if (frame_err) begin
          state_next = ST_ERR;
        end else if (byte_valid) begin
          if (len_rx == '0)                           state_next = ST_AFTER_DATA;
          else if (32'(len_rx) > 32'(MAX_WORDS))      state_next = ST_ERR;
          else                                        state_next = ST_DATA;
        end
      end
      ST_DATA: begin
        if (frame_err)                                          state_next = ST_ERR;
        else if (byte_valid && byte_idx == 2'd3 && last_word)   state_next = ST_AFTER_DATA;
      end
`ifdef ROM_LOADER_CSUM_EN
      ST_CSUM: begin
        if (frame_err)       state_next = ST_ERR;
        else if (byte_valid) state_next = (rx_byte == csum) ? ST_DONE : ST_ERR;
      end
`endif
      ST_DONE, ST_ERR: if (!load_req_i) state_next = ST_IDLE;
      default: state_next = ST_IDLE;
    endcase
    // Dropping the request wins over any byte or error arriving this cycle.
    if (abort) state_next = ST_IDLE;
  end

  // Datapath: length capture, word packing and the registered write port.
  always_ff @(posedge clk) begin
    if (rst) begin
      wen_o    <= 1'b0;
      w_addr_o <= '0;
      w_data_o <= '0;
      len_lo   <= '0;
      n_words  <= '0;
      word_cnt <= '0;
      byte_idx <= '0;
      word_buf <= '0;
`ifdef ROM_LOADER_CSUM_EN
      csum     <= '0;
`endif
    end else begin
      wen_o <= 1'b0;
      if (byte_valid && !abort) begin
        case (state)
          ST_LEN0: len_lo <= rx_byte;
          ST_LEN1: begin
            n_words  <= len_rx;
            word_cnt <= '0;
            byte_idx <= '0;
`ifdef ROM_LOADER_CSUM_EN
            csum     <= '0;
`endif
          end
          ST_DATA: begin
            byte_idx <= byte_idx + 2'd1;
            word_buf <= {rx_byte, word_buf[23:8]};
`ifdef ROM_LOADER_CSUM_EN
            csum     <= csum + rx_byte;
`endif
            if (byte_idx == 2'd3) begin
              wen_o    <= 1'b1;
              w_addr_o <= BASE_ADDR + {14'd0, word_cnt, 2'b00};
              w_data_o <= {rx_byte, word_buf};
              word_cnt <= word_cnt + LEN_W'(1);
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule
